serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the team's single-bit full_adder cell (A, B, C -> SUM, Cout).
- Operands are loaded on a start request and shifted LSB-first through one full_adder slice, one bit per clock.
- A registered carry closes the loop between bits.
- The result is presented with a one-cycle done pulse.
- Sits downstream of operand registers and is the area-minimal alternative to a ripple-carry array of full_adder cells.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter must index 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the arithmetic slice of the serial adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ c_i;
  assign cout_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice, LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_sum, fa_cout;
  logic             load;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic [WIDTH-1:0] sr_shift;
  logic             sr_unused;

  full_adder u_fa (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .c_i    (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // Subtraction is a + ~b + 1: invert b and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign sr_shift  = {fa_sum, sr_q[WIDTH-1:1]};
  assign sr_unused = sr_q[0];

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) load = 1'b1;
      end
      ST_RUN: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        sr_d    = sr_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sr_shift;
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (start) load = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      sa_d    = a;
      sb_d    = b_ld;
      sr_d    = '0;
      carry_d = c_ld;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit and a 2-bit instance against an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub2;
`endif

  int total  = 0;
  int passed = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  // Drives one operation on the selected instance and waits for done (bounded).
  // lat counts clock edges from the accepting edge to the edge that raises done.
  task automatic do_op(input bit w2, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, output logic [31:0] s, output logic co,
                       output int lat, output int busy_n, output int overlap);
    logic d, bz;
    @(negedge clk);
    if (w2) begin
      a2 = a[1:0]; b2 = b[1:0]; cin2 = cin; start2 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; start8 = 1'b1;
    end
    @(negedge clk);
    start2 = 1'b0;
    start8 = 1'b0;
    lat = 0; busy_n = 0; overlap = 0;
    while (lat < 64) begin
      d  = w2 ? done2 : done8;
      bz = w2 ? busy2 : busy8;
      if (d && bz) overlap++;
      if (d) break;
      if (bz) busy_n++;
      @(negedge clk);
      lat++;
    end
    s  = w2 ? 32'(sum2) : 32'(sum8);
    co = w2 ? cout2 : cout8;
  endtask

  function automatic longint model_add(input int w, input longint a, input longint b,
                                       input longint cin);
    return (a + b + cin) % (longint'(1) << (w + 1));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 0; sub2 = 0;
`endif
    repeat (3) @(negedge clk);
    total++; if ({busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%0d, want all 0", busy8, done8, cout8, sum8);
    else passed++;
    total++; if ({busy2, done2, cout2, sum2} !== 5'd0)
      $display("FAIL reset2: got busy=%b done=%b cout=%b sum=%0d, want all 0", busy2, done2, cout2, sum2);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] s; logic co; int lat, bn, ov;
    do_op(0, 100, 55, 0, s, co, lat, bn, ov);
    total++; if (s !== 155 || co !== 1'b0)
      $display("FAIL basic_sum: got %0d/%b, want 155/0", s, co); else passed++;
    total++; if (lat !== 8)
      $display("FAIL basic_latency: got %0d edges, want 8", lat); else passed++;
    total++; if (bn !== 8)
      $display("FAIL basic_busy_cycles: got %0d, want 8", bn); else passed++;
    total++; if (ov !== 0)
      $display("FAIL basic_busy_done_overlap: got %0d, want 0", ov); else passed++;
  endtask

  task automatic test_carry_out();
    logic [31:0] s; logic co; int lat, bn, ov;
    do_op(0, 200, 100, 0, s, co, lat, bn, ov);
    total++; if (s !== 44 || co !== 1'b1)
      $display("FAIL carry_200_100: got %0d/%b, want 44/1", s, co); else passed++;
    do_op(0, 255, 0, 1, s, co, lat, bn, ov);
    total++; if (s !== 0 || co !== 1'b1)
      $display("FAIL carry_255_0_1: got %0d/%b, want 0/1", s, co); else passed++;
    do_op(0, 255, 255, 1, s, co, lat, bn, ov);
    total++; if (s !== 255 || co !== 1'b1)
      $display("FAIL carry_max: got %0d/%b, want 255/1", s, co); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] s, ra, rb; logic co, rc; int lat, bn, ov; longint e;
    for (int i = 0; i < 25; i++) begin
      ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); rc = 1'($urandom_range(0, 1));
      e = model_add(8, ra, rb, longint'(rc));
      do_op(0, ra, rb, rc, s, co, lat, bn, ov);
      total++; if ({co, s[7:0]} !== 9'(e) || lat !== 8)
        $display("FAIL random8 %0d+%0d+%0d: got %0d/%b lat %0d, want %0d/%b lat 8",
                 ra, rb, rc, s, co, lat, e % 256, e / 256);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int lat, ndone; logic saw_gap;
    @(negedge clk);
    a8 = 50; b8 = 60; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done8 && lat < 64) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    total++; if (sum8 !== 110 || cout8 !== 1'b0 || lat !== 8)
      $display("FAIL held_start_first: got %0d/%b lat %0d, want 110/0 lat 8", sum8, cout8, lat);
    else passed++;
    a8 = 1; b8 = 2; cin8 = 0;
    @(negedge clk);
    saw_gap = !busy8 || done8;
    start8 = 1'b0;
    total++; if (saw_gap !== 1'b0)
      $display("FAIL back_to_back_gap: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
    else passed++;
    lat = 0; ndone = 0;
    while (!done8 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    total++; if (sum8 !== 3 || cout8 !== 1'b0 || lat !== 8)
      $display("FAIL back_to_back_second: got %0d/%b lat %0d, want 3/0 lat 8", sum8, cout8, lat);
    else passed++;
    repeat (4) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    total++; if (ndone !== 0)
      $display("FAIL done_single_pulse: got %0d extra done cycles, want 0", ndone); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s; logic co; int lat, bn, ov, seen;
    @(negedge clk);
    a8 = 200; b8 = 100; cin8 = 1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL reset_mid_run: got busy=%b done=%b cout=%b sum=%0d, want all 0", busy8, done8, cout8, sum8);
    else passed++;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8 || done8) seen++;
    end
    total++; if (seen !== 0)
      $display("FAIL reset_discards_op: got %0d active cycles, want 0", seen); else passed++;
    do_op(0, 3, 4, 0, s, co, lat, bn, ov);
    total++; if (s !== 7 || co !== 1'b0 || lat !== 8)
      $display("FAIL after_reset_3_4: got %0d/%b lat %0d, want 7/0 lat 8", s, co, lat);
    else passed++;
  endtask

  task automatic test_width2();
    logic [31:0] s, ra, rb; logic co, rc; int lat, bn, ov; longint e;
    do_op(1, 3, 3, 1, s, co, lat, bn, ov);
    total++; if (s !== 3 || co !== 1'b1 || lat !== 2 || bn !== 2)
      $display("FAIL width2_3_3_1: got %0d/%b lat %0d busy %0d, want 3/1 lat 2 busy 2", s, co, lat, bn);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom_range(0, 3); rb = $urandom_range(0, 3); rc = 1'($urandom_range(0, 1));
      e = model_add(2, ra, rb, longint'(rc));
      do_op(1, ra, rb, rc, s, co, lat, bn, ov);
      total++; if ({co, s[1:0]} !== 3'(e) || lat !== 2)
        $display("FAIL random2 %0d+%0d+%0d: got %0d/%b lat %0d, want %0d/%b lat 2",
                 ra, rb, rc, s, co, lat, e % 4, e / 4);
      else passed++;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [31:0] s, ra, rb; logic co; int lat, bn, ov; longint diff;
    sub8 = 1'b1;
    do_op(0, 10, 3, 0, s, co, lat, bn, ov);
    total++; if (s !== 7 || co !== 1'b1)
      $display("FAIL sub_10_3: got %0d/%b, want 7/1", s, co); else passed++;
    do_op(0, 3, 10, 1, s, co, lat, bn, ov);
    total++; if (s !== 249 || co !== 1'b0)
      $display("FAIL sub_3_10: got %0d/%b, want 249/0", s, co); else passed++;
    for (int i = 0; i < 10; i++) begin
      ra = $urandom_range(0, 255); rb = $urandom_range(0, 255);
      diff = (longint'(ra) - longint'(rb) + 256) % 256;
      do_op(0, ra, rb, 1'($urandom_range(0, 1)), s, co, lat, bn, ov);
      total++; if (s !== 32'(diff) || co !== (ra >= rb))
        $display("FAIL sub_random %0d-%0d: got %0d/%b, want %0d/%b", ra, rb, s, co, diff, ra >= rb);
      else passed++;
    end
    sub8 = 1'b0;
    do_op(0, 10, 3, 0, s, co, lat, bn, ov);
    total++; if (s !== 13 || co !== 1'b0)
      $display("FAIL sub_off_add: got %0d/%b, want 13/0", s, co); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_out();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width2();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
